cex_capture: RTL and testbench
==============================

# cex_capture

Downstream consumer of the two-automaton equivalence bench. Watches both automata's accept outputs together with the shared input symbol stream. On the first divergence after an automaton reset, it freezes the input prefix that caused it, so the failing word can be read out and replayed. The frozen word is presented over a valid/ready handshake.

## Interface
Parameters:
- MAX_LEN, 32: maximum captured word length in symbols.
- LEN_W, $clog2(MAX_LEN+1): width of the length field.

Ports:
- clk  in  1  bench clock, shared with both automata.
- reset_n  in  1  asynchronous, active-low block reset.
- sync_rst  in  1  the same active-high pulse that resets the automata; marks the start of a new word.
- in_bit  in  1  input symbol applied to both automata this cycle.
- out1  in  1  accept output of automaton 1.
- out2  in  1  accept output of automaton 2.
- cex_valid  out  1  counterexample available.
- cex_ready  in  1  consumer accepts the counterexample.
- cex_len  out  LEN_W  number of symbols in the counterexample (0 = empty word).
- cex_word  out  MAX_LEN  symbols; bit 0 is the first symbol; bits at and above cex_len are 0.
- cex_acc1  out  1  value of out1 at divergence.
- overflow  out  1  sticky; MAX_LEN symbols consumed with no divergence.
- rst_missed  out  1  one-cycle pulse: sync_rst arrived while in HOLD.
- mismatch_cnt  out  16  captured-counterexample count (see Configuration).

## Operation
- State machine: IDLE, RUN, HOLD, FULL.
- On reset_n low, all outputs are forced to 0 and the state is IDLE.
- sync_rst in IDLE, RUN or FULL:
  - clear the word buffer, len, overflow and cex_acc1;
  - next state is RUN.
- In a RUN cycle with len = k, out1/out2 reflect the prefix word[0..k-1]:
  - out1 != out2: latch cex_len = k, cex_acc1 = out1, and the buffer; next state HOLD. in_bit is not stored.
  - out1 == out2 and k < MAX_LEN: word[k] <= in_bit, len <= k+1.
  - out1 == out2 and k == MAX_LEN: overflow <= 1; next state FULL.
- HOLD: cex_valid = 1 and the outputs are stable. When cex_valid && cex_ready, next state is IDLE.
  - sync_rst in HOLD is ignored and rst_missed pulses, so the pending counterexample is never overwritten.
- FULL: no comparison is made; wait for sync_rst.
- IDLE: inputs are ignored except sync_rst.
- sync_rst in the same cycle as a RUN mismatch: sync_rst wins and no capture is made.
- In any state, reset_n assertion mid-operation discards everything immediately.

## Timing
- Capture latency: cex_valid rises 1 cycle after the mismatching RUN cycle.
- The first RUN cycle is the cycle after sync_rst; it compares the empty word.
- Handshake: cex_valid holds until accepted. cex_ready while cex_valid is low has no effect.
- Earliest restart is the cycle after acceptance (IDLE), taking sync_rst that cycle.
- The overflow flag sets 1 cycle after the RUN cycle with len = MAX_LEN.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- CEX_COUNT_EN defined:
  - mismatch_cnt increments on each HOLD entry;
  - it saturates at 16'hFFFF;
  - it is cleared only by reset_n.
- CEX_COUNT_EN undefined: mismatch_cnt is tied to 0 and no counter logic exists.

## Structure
- Package cex_pkg holds:
  - the state enum (IDLE, RUN, HOLD, FULL);
  - the MAX_LEN default;
  - the counter width constant (16).
- Sub-module cex_word_buf:
  - indexed single-bit writer with synchronous clear and freeze;
  - owns the word register and len counter.
- The top level holds the FSM, the capture registers and the optional counter.

## Test plan
- Empty word: sync_rst, then first RUN cycle out1=1, out2=0 -> cex_valid next cycle, cex_len=0, cex_word=0, cex_acc1=1.
- Prefix 1,0,1 with out1==out2, then out1=0/out2=1 at len=3 -> cex_len=3, cex_word=32'h5, cex_acc1=0.
- Handshake: hold cex_ready=0 for 5 cycles -> outputs stable; cex_ready=1 -> cex_valid low next cycle, state IDLE.
- MAX_LEN=4 with no divergence over 4 symbols -> overflow=1 and cex_valid stays 0; sync_rst clears overflow.
- sync_rst during HOLD -> rst_missed pulses and cex_len/cex_word are unchanged; sync_rst coincident with a RUN mismatch -> no capture.
- reset_n low mid-RUN at len=2 -> all outputs 0 immediately; with CEX_COUNT_EN, three captures -> mismatch_cnt=3.

Source files
------------

// File: rtl/cex_pkg.sv
// Shared types and constants for the counterexample capture block.
// State encoding, default word length, and event counter width.
package cex_pkg;

   localparam int CEX_MAX_LEN = 32;
   localparam int CNT_W       = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_FULL = 2'd3
   } cex_state_t;

endpackage

// File: rtl/cex_word_buf.sv
// Symbol buffer: appends one bit per write at index len, synchronous clear, writes blocked by freeze.
// Latency 1 cycle per write; no backpressure, writes past MAX_LEN are dropped and flagged by full.
module cex_word_buf
   import cex_pkg::*;
#(
   parameter int MAX_LEN = CEX_MAX_LEN,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clr,
   input  logic               wr_en,
   input  logic               freeze,
   input  logic               sym,
   output logic [MAX_LEN-1:0] word,
   output logic [LEN_W-1:0]   len,
   output logic               full
);

   logic do_write;

   assign full     = (len == LEN_W'(MAX_LEN));
   assign do_write = wr_en && !freeze && !full;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word <= '0;
         len  <= '0;
      end else if (clr) begin
         word <= '0;
         len  <= '0;
      end else if (do_write) begin
         // Decoded write keeps the index compare at LEN_W bits.
         for (int i = 0; i < MAX_LEN; i++) begin
            if (len == LEN_W'(i)) begin
               word[i] <= sym;
            end
         end
         len <= len + LEN_W'(1);
      end
   end

endmodule

// File: rtl/cex_capture.sv
// Freezes the input prefix at the first accept divergence of two automata; optional CEX_COUNT_EN counter.
// Latency: cex_valid rises 1 cycle after the mismatching cycle; held until cex_valid && cex_ready.
// Backpressure: while a word is held, new sync_rst requests are dropped and reported on rst_missed.
module cex_capture
   import cex_pkg::*;
#(
   parameter int MAX_LEN = CEX_MAX_LEN,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               sync_rst,
   input  logic               in_bit,
   input  logic               out1,
   input  logic               out2,
   output logic               cex_valid,
   input  logic               cex_ready,
   output logic [LEN_W-1:0]   cex_len,
   output logic [MAX_LEN-1:0] cex_word,
   output logic               cex_acc1,
   output logic               overflow,
   output logic               rst_missed,
   output logic [CNT_W-1:0]   mismatch_cnt
);

   cex_state_t         state;
   cex_state_t         state_nxt;
   logic [MAX_LEN-1:0] buf_word;
   logic [LEN_W-1:0]   buf_len;
   logic               buf_full;
   logic               in_run;
   logic               in_hold;
   logic               buf_clr;
   logic               agree;
   logic               diverge;
   logic               buf_wr;
   logic               ovf_set;
   logic               accept;

   assign in_run  = (state == ST_RUN);
   assign in_hold = (state == ST_HOLD);
   // A new word request outranks anything the RUN comparison would do this cycle.
   assign buf_clr = sync_rst && !in_hold;
   assign agree   = (out1 == out2);
   assign diverge = in_run && !sync_rst && !agree;
   assign buf_wr  = in_run && !sync_rst && agree;
   assign ovf_set = buf_wr && buf_full;
   assign accept  = cex_valid && cex_ready;

   cex_word_buf #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_word_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (buf_clr),
      .wr_en   (buf_wr),
      .freeze  (in_hold),
      .sym     (in_bit),
      .word    (buf_word),
      .len     (buf_len),
      .full    (buf_full)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_HOLD: begin
            if (accept) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (sync_rst) begin
               state_nxt = ST_RUN;
            end else if (!agree) begin
               state_nxt = ST_HOLD;
            end else if (buf_full) begin
               state_nxt = ST_FULL;
            end
         end
         default: begin
            if (sync_rst) begin
               state_nxt = ST_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cex_valid  <= 1'b0;
         cex_len    <= '0;
         cex_word   <= '0;
         cex_acc1   <= 1'b0;
         overflow   <= 1'b0;
         rst_missed <= 1'b0;
      end else begin
         state      <= state_nxt;
         rst_missed <= in_hold && sync_rst;
         if (buf_clr) begin
            cex_len  <= '0;
            cex_word <= '0;
            cex_acc1 <= 1'b0;
            overflow <= 1'b0;
         end else if (diverge) begin
            cex_valid <= 1'b1;
            cex_len   <= buf_len;
            cex_word  <= buf_word;
            cex_acc1  <= out1;
         end else if (ovf_set) begin
            overflow <= 1'b1;
         end
         if (accept) begin
            cex_valid <= 1'b0;
         end
      end
   end

`ifdef CEX_COUNT_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (diverge && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign mismatch_cnt = cnt;
`else
   assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_cex_capture.sv
// Bench for cex_capture with MAX_LEN=4: directed cases plus randomized traffic against a word-level model.
module tb_cex_capture;

   localparam int ML = 4;
   localparam int LW = $clog2(ML + 1);

`ifdef CEX_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk       = 1'b0;
   logic          reset_n   = 1'b1;
   logic          sync_rst  = 1'b0;
   logic          in_bit    = 1'b0;
   logic          out1      = 1'b0;
   logic          out2      = 1'b0;
   logic          cex_ready = 1'b0;
   logic          cex_valid;
   logic [LW-1:0] cex_len;
   logic [ML-1:0] cex_word;
   logic          cex_acc1;
   logic          overflow;
   logic          rst_missed;
   logic [15:0]   mismatch_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cex_capture #(.MAX_LEN(ML), .LEN_W(LW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sync_rst     (sync_rst),
      .in_bit       (in_bit),
      .out1         (out1),
      .out2         (out2),
      .cex_valid    (cex_valid),
      .cex_ready    (cex_ready),
      .cex_len      (cex_len),
      .cex_word     (cex_word),
      .cex_acc1     (cex_acc1),
      .overflow     (overflow),
      .rst_missed   (rst_missed),
      .mismatch_cnt (mismatch_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Word-level model: the symbols seen since the last word start, and the pending capture.
   localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_FULL = 3;
   int            m_mode  = M_IDLE;
   bit            m_syms[$];
   logic          e_valid = 1'b0;
   logic          e_acc1  = 1'b0;
   logic          e_ovf   = 1'b0;
   logic          e_miss  = 1'b0;
   logic [LW-1:0] e_len   = '0;
   logic [ML-1:0] e_word  = '0;
   logic [15:0]   e_cnt   = '0;

   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_mode = M_IDLE;
            m_syms.delete();
            e_valid = 0; e_acc1 = 0; e_ovf = 0; e_miss = 0;
            e_len = '0; e_word = '0; e_cnt = '0;
         end else begin
            e_miss = 0;
            if (m_mode == M_HOLD) begin
               if (sync_rst) e_miss = 1;
               if (cex_ready) begin
                  m_mode  = M_IDLE;
                  e_valid = 0;
               end
            end else if (sync_rst) begin
               m_syms.delete();
               e_ovf = 0; e_acc1 = 0; e_len = '0; e_word = '0;
               m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
               if (out1 != out2) begin
                  e_valid = 1;
                  e_len   = LW'(m_syms.size());
                  e_word  = '0;
                  foreach (m_syms[i]) e_word = e_word | (ML'(m_syms[i]) << i);
                  e_acc1  = out1;
                  m_mode  = M_HOLD;
                  if (CNT_EN && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
               end else if (m_syms.size() < ML) begin
                  m_syms.push_back(in_bit);
               end else begin
                  e_ovf  = 1;
                  m_mode = M_FULL;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("valid", 32'(cex_valid), 32'(e_valid));
         chk("overflow", 32'(overflow), 32'(e_ovf));
         chk("rst_missed", 32'(rst_missed), 32'(e_miss));
         chk("mismatch_cnt", 32'(mismatch_cnt), 32'(e_cnt));
         if (e_valid) begin
            chk("cex_len", 32'(cex_len), 32'(e_len));
            chk("cex_word", 32'(cex_word), 32'(e_word));
            chk("cex_acc1", 32'(cex_acc1), 32'(e_acc1));
         end
      end
   end

   task automatic step(input logic s, input logic b, input logic o1, input logic o2, input logic r);
      sync_rst = s; in_bit = b; out1 = o1; out2 = o2; cex_ready = r;
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(cex_valid), 32'd0);
      chk({tag, "_len"}, 32'(cex_len), 32'd0);
      chk({tag, "_word"}, 32'(cex_word), 32'd0);
      chk({tag, "_acc1"}, 32'(cex_acc1), 32'd0);
      chk({tag, "_ovf"}, 32'(overflow), 32'd0);
      chk({tag, "_miss"}, 32'(rst_missed), 32'd0);
      chk({tag, "_cnt"}, 32'(mismatch_cnt), 32'd0);
   endtask

   initial begin
      logic s, b, o1, o2, r;
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk_all_zero("reset");
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);

      // Empty word: divergence in the very first RUN cycle.
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("empty_valid", 32'(cex_valid), 32'd1);
      chk("empty_len", 32'(cex_len), 32'd0);
      chk("empty_word", 32'(cex_word), 32'd0);
      chk("empty_acc1", 32'(cex_acc1), 32'd1);
      step(0, 0, 0, 0, 1);
      chk("empty_accept", 32'(cex_valid), 32'd0);

      // Prefix 1,0,1 then divergence at len 3.
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      step(0, 1, 1, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("p101_valid", 32'(cex_valid), 32'd1);
      chk("p101_len", 32'(cex_len), 32'd3);
      chk("p101_word", 32'(cex_word), 32'h5);
      chk("p101_acc1", 32'(cex_acc1), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
         chk("hold_valid", 32'(cex_valid), 32'd1);
         chk("hold_len", 32'(cex_len), 32'd3);
         chk("hold_word", 32'(cex_word), 32'h5);
      end
      step(1, 0, 1, 0, 0);
      chk("hold_rst_miss", 32'(rst_missed), 32'd1);
      chk("hold_rst_len", 32'(cex_len), 32'd3);
      chk("hold_rst_word", 32'(cex_word), 32'h5);
      chk("hold_rst_valid", 32'(cex_valid), 32'd1);
      step(0, 0, 0, 0, 0);
      chk("miss_pulse_end", 32'(rst_missed), 32'd0);
      step(0, 0, 0, 0, 1);
      chk("p101_accept", 32'(cex_valid), 32'd0);
      step(0, 0, 1, 0, 1);
      chk("idle_ready", 32'(cex_valid), 32'd0);

      // Overflow: four agreeing symbols, then the len=MAX_LEN cycle.
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0);
      chk("pre_ovf", 32'(overflow), 32'd0);
      step(0, 0, 1, 1, 0);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_novalid", 32'(cex_valid), 32'd0);
      step(0, 0, 1, 0, 0);
      chk("full_nocmp", 32'(cex_valid), 32'd0);
      chk("full_sticky", 32'(overflow), 32'd1);
      step(1, 0, 0, 0, 0);
      chk("ovf_clear", 32'(overflow), 32'd0);

      // sync_rst coincident with a RUN mismatch: no capture.
      step(1, 0, 1, 0, 0);
      chk("coincide_nocap", 32'(cex_valid), 32'd0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0);

      // reset_n mid-RUN at len 2.
      #2 reset_n = 1'b0;
      #1 chk_all_zero("midrun");
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 0);
         step(0, 0, 1, 0, 0);
         step(0, 0, 0, 0, 1);
      end
      chk("three_caps", 32'(mismatch_cnt), CNT_EN ? 32'd3 : 32'd0);

      // Randomized traffic, checked every cycle against the model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            #2 reset_n = 1'b0;
            @(negedge clk);
            #2 reset_n = 1'b1;
         end
         s  = ($urandom_range(0, 9) == 0);
         b  = 1'($urandom);
         o1 = 1'($urandom);
         o2 = ($urandom_range(0, 5) == 0) ? ~o1 : o1;
         r  = ($urandom_range(0, 2) == 0);
         step(s, b, o1, o2, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
